// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 field constants, FSM state encoding and a small modular add
// helper used by the point decompressor and the other point arithmetic blocks.
package secp256k1_pkg;

    // Field prime p = 2^256 - 2^32 - 977.
    localparam logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    // Square-root exponent (p+1)/4; valid because p = 3 mod 4.
    localparam logic [255:0] SQRT_EXP = 256'h3FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_BFFFFF0C;

    // Curve constant b in y^2 = x^3 + b.
    localparam logic [255:0] B = 256'd7;

    // 2^256 mod p, used to fold the high half of a product back into range.
    localparam logic [32:0] RED_C = 33'h1_000003D1;

    // Bit 253 of SQRT_EXP is consumed by starting the exponentiation at r = a,
    // so the square-and-multiply walk begins at bit 252.
    localparam logic [7:0] EXP_TOP_BIT = 8'd252;

    // SEC1 compressed point prefixes.
    localparam logic [7:0] PREFIX_EVEN = 8'h02;
    localparam logic [7:0] PREFIX_ODD  = 8'h03;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CUBE  = 3'd1,
        EXP   = 3'd2,
        CHECK = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } dec_state_e;

    // (a + b) mod p for operands already reduced into [0, p-1].
    function automatic logic [255:0] add_mod(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) begin
            s = s - {1'b0, P};
        end
        return s[255:0];
    endfunction

endpackage

// File: rtl/mod_mult.sv
// Combinational (a * b) mod p for secp256k1 using the 2^256 = 2^32 + 977
// folding identity instead of a generic divider.
module mod_mult
    import secp256k1_pkg::*;
(
    input  logic [255:0] a_i,
    input  logic [255:0] b_i,
    output logic [255:0] p_o
);

    logic [511:0] prod;
    logic [289:0] fold1;
    logic [256:0] fold2;

    // Full product, then two folds of the high part by 2^256 mod p; after the
    // second fold the value is below 2^256 + 2^67, so one conditional subtract
    // of p lands it in [0, p-1].
    always_comb begin
        prod  = {256'd0, a_i} * {256'd0, b_i};
        fold1 = {34'd0, prod[255:0]} + ({34'd0, prod[511:256]} * {257'd0, RED_C});
        fold2 = {1'b0, fold1[255:0]} + ({223'd0, fold1[289:256]} * {224'd0, RED_C});
        if (fold2 >= {1'b0, P}) begin
            p_o = fold2[255:0] - P;
        end else begin
            p_o = fold2[255:0];
        end
    end

endmodule

// File: rtl/mod_sub.sv
// Combinational (a - b) mod p; the minuend may be p itself, which is how the
// decompressor forms the negated root p - r.
module mod_sub
    import secp256k1_pkg::*;
(
    input  logic [255:0] a_i,
    input  logic [255:0] b_i,
    output logic [255:0] d_o
);

    // Wrap-around subtraction at 256 bits; adding p back when a < b yields the
    // true residue because the mathematical result lies in [0, p-1].
    always_comb begin
        if (a_i >= b_i) begin
            d_o = a_i - b_i;
        end else begin
            d_o = a_i - b_i + P;
        end
    end

endmodule

// File: rtl/point_decompress.sv
// SEC1 compressed-point decompressor for secp256k1: recovers y from x and the
// parity prefix with a single shared modular multiplier stepping through a
// fixed-length square-and-multiply schedule.
module point_decompress
    import secp256k1_pkg::*;
#(
    parameter int CHECK_ON_CURVE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_prefix,
    input  logic [255:0] in_x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_x,
    output logic [255:0] out_y,
    output logic         out_err
);

    dec_state_e   state_q, state_d;
    logic [255:0] x_q, x_d;
    logic [7:0]   prefix_q, prefix_d;
    logic [255:0] a_q, a_d;
    logic [255:0] r_q, r_d;
    logic [255:0] y_q, y_d;
    logic         err_q, err_d;
    logic [7:0]   bitIdx_q, bitIdx_d;
    logic         phase_q, phase_d;

    logic [255:0] mulA;
    logic [255:0] mulB;
    logic [255:0] mulP;
    logic [255:0] subD;

    mod_mult u_mult (
        .a_i (mulA),
        .b_i (mulB),
        .p_o (mulP)
    );

    mod_sub u_sub (
        .a_i (P),
        .b_i (r_q),
        .d_o (subD)
    );

    // Next-state and datapath control: selects the multiplier operands for the
    // current step and decides where each result is stored.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        prefix_d = prefix_q;
        a_d      = a_q;
        r_d      = r_q;
        y_d      = y_q;
        err_d    = err_q;
        bitIdx_d = bitIdx_q;
        phase_d  = phase_q;
        mulA     = r_q;
        mulB     = r_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d      = in_x;
                    prefix_d = in_prefix;
                    a_d      = '0;
                    r_d      = '0;
                    y_d      = '0;
                    phase_d  = 1'b0;
                    bitIdx_d = EXP_TOP_BIT;
                    if (((in_prefix != PREFIX_EVEN) && (in_prefix != PREFIX_ODD)) || (in_x >= P)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = CUBE;
                    end
                end
            end

            CUBE: begin
                if (!phase_q) begin
                    mulA    = x_q;
                    mulB    = x_q;
                    a_d     = mulP;
                    phase_d = 1'b1;
                end else begin
                    mulA     = a_q;
                    mulB     = x_q;
                    a_d      = add_mod(mulP, B);
                    r_d      = add_mod(mulP, B);
                    phase_d  = 1'b0;
                    bitIdx_d = EXP_TOP_BIT;
                    state_d  = EXP;
                end
            end

            EXP: begin
                if (!phase_q) begin
                    mulA = r_q;
                    mulB = r_q;
                    r_d  = mulP;
                    if (SQRT_EXP[bitIdx_q]) begin
                        phase_d = 1'b1;
                    end else if (bitIdx_q == 8'd0) begin
                        state_d = CHECK;
                    end else begin
                        bitIdx_d = bitIdx_q - 8'd1;
                    end
                end else begin
                    mulA    = r_q;
                    mulB    = a_q;
                    r_d     = mulP;
                    phase_d = 1'b0;
                    if (bitIdx_q == 8'd0) begin
                        state_d = CHECK;
                    end else begin
                        bitIdx_d = bitIdx_q - 8'd1;
                    end
                end
            end

            CHECK: begin
                mulA = r_q;
                mulB = r_q;
                if ((CHECK_ON_CURVE != 0) && (mulP != a_q)) begin
                    err_d = 1'b1;
                end
                state_d = FIX;
            end

            FIX: begin
                if (err_q) begin
                    y_d = '0;
                end else if (r_q == '0) begin
                    y_d = '0;
                    if (prefix_q == PREFIX_ODD) begin
                        err_d = 1'b1;
                    end
                end else if (r_q[0] != prefix_q[0]) begin
                    y_d = subD;
                end else begin
                    y_d = r_q;
                end
                state_d = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset to a clean idle block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            prefix_q <= '0;
            a_q      <= '0;
            r_q      <= '0;
            y_q      <= '0;
            err_q    <= 1'b0;
            bitIdx_q <= '0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            prefix_q <= prefix_d;
            a_q      <= a_d;
            r_q      <= r_d;
            y_q      <= y_d;
            err_q    <= err_d;
            bitIdx_q <= bitIdx_d;
            phase_q  <= phase_d;
        end
    end

    // Handshake flags come straight from the state; result fields are held
    // registers so they stay stable for as long as DONE waits.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_x     = x_q;
        out_y     = y_q;
        out_err   = err_q;
    end

endmodule

// File: tb/tb_point_decompress.sv
// Self-checking bench for point_decompress against a plain modular-arithmetic
// reference model of SEC1 point decompression.
module tb_point_decompress;

    localparam logic [255:0] MODP = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] GX   = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam logic [255:0] GY   = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
    localparam logic [255:0] GYN  = 256'hB7C52588_D95C3B9A_A25B0403_F1EEF757_02E84BB7_597AABE6_63B82F6F_04EF2777;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_prefix;
    logic [255:0] in_x;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_x;
    logic [255:0] out_y;
    logic         out_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    point_decompress #(.CHECK_ON_CURVE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prefix (in_prefix),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_err   (out_err)
    );

    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
        return 256'(({256'd0, a} * {256'd0, b}) % {256'd0, MODP});
    endfunction

    function automatic logic [255:0] powmod(input logic [255:0] base, input logic [255:0] e);
        logic [255:0] res;
        logic [255:0] bb;
        res = 256'd1;
        bb  = base;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) res = mulmod(res, bb);
            bb = mulmod(bb, bb);
        end
        return res;
    endfunction

    function automatic void refModel(input logic [7:0] pre, input logic [255:0] x,
                                     output logic [255:0] y, output logic err, output int lat);
        logic [255:0] alpha;
        logic [255:0] beta;
        logic [255:0] expo;
        logic [255:0] cube;
        y   = '0;
        err = 1'b0;
        lat = 504;
        if (((pre != 8'h02) && (pre != 8'h03)) || (x >= MODP)) begin
            err = 1'b1;
            lat = 1;
            return;
        end
        expo  = {2'b00, MODP[255:2]} + 256'd1;
        cube  = mulmod(mulmod(x, x), x);
        alpha = 256'(({1'b0, cube} + 257'd7) % {1'b0, MODP});
        beta  = powmod(alpha, expo);
        if (mulmod(beta, beta) != alpha) begin
            err = 1'b1;
            return;
        end
        if (beta == '0) begin
            err = (pre == 8'h03);
            return;
        end
        y = (beta[0] == pre[0]) ? beta : (MODP - beta);
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic applyStimulus(input logic [7:0] pre, input logic [255:0] x, output int waitCycles);
        int n;
        n = 0;
        in_prefix = pre;
        in_x      = x;
        in_valid  = 1'b1;
        while (in_ready !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        waitCycles = n;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic awaitOutput(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_prefix = '0; in_x = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_err: got %b expected 0", out_err); end
        checks++; if (out_x !== '0) begin errors++; $display("[TB] FAIL reset_out_x: got %h expected 0", out_x); end
        checks++; if (out_y !== '0) begin errors++; $display("[TB] FAIL reset_out_y: got %h expected 0", out_y); end
    endtask

    task automatic test_generator(input logic [7:0] pre, input logic [255:0] expY, input bit firstAfterReset);
        int wc, lat;
        applyStimulus(pre, GX, wc);
        if (firstAfterReset) begin
            checks++; if (wc != 0) begin errors++; $display("[TB] FAIL first_accept_wait: got %0d expected 0", wc); end
        end
        awaitOutput(lat);
        checks++; if (lat != 504) begin errors++; $display("[TB] FAIL gen_latency pre=%h: got %0d expected 504", pre, lat); end
        checks++; if (out_y !== expY) begin errors++; $display("[TB] FAIL gen_y pre=%h: got %h expected %h", pre, out_y, expY); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL gen_err pre=%h: got %b expected 0", pre, out_err); end
        checks++; if (out_x !== GX) begin errors++; $display("[TB] FAIL gen_x pre=%h: got %h expected %h", pre, out_x, GX); end
        releaseResult();
    endtask

    task automatic test_reject();
        logic [7:0]   pres [4];
        logic [255:0] xs   [4];
        int wc, lat;
        pres[0] = 8'h04; xs[0] = GX;
        pres[1] = 8'h02; xs[1] = MODP;
        pres[2] = 8'h00; xs[2] = rand256() >> 1;
        pres[3] = 8'h03; xs[3] = MODP + 256'($urandom_range(1, 900));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(pres[i], xs[i], wc);
            awaitOutput(lat);
            checks++; if (lat != 1) begin errors++; $display("[TB] FAIL reject_latency #%0d: got %0d expected 1", i, lat); end
            checks++; if (out_err !== 1'b1) begin errors++; $display("[TB] FAIL reject_err #%0d: got %b expected 1", i, out_err); end
            checks++; if (out_y !== '0) begin errors++; $display("[TB] FAIL reject_y #%0d: got %h expected 0", i, out_y); end
            releaseResult();
        end
    endtask

    task automatic test_non_residue();
        logic [255:0] x, ey;
        logic [7:0]   pre;
        logic         ee;
        int           el, wc, lat, tries;
        tries = 0;
        do begin
            x   = rand256();
            pre = 8'h02 + 8'($urandom_range(0, 1));
            refModel(pre, x, ey, ee, el);
            tries++;
        end while (!(ee && el == 504) && tries < 64);
        applyStimulus(pre, x, wc);
        awaitOutput(lat);
        checks++; if (lat != 504) begin errors++; $display("[TB] FAIL nonres_latency: got %0d expected 504", lat); end
        checks++; if (out_err !== ee) begin errors++; $display("[TB] FAIL nonres_err: got %b expected %b", out_err, ee); end
        checks++; if (out_y !== ey) begin errors++; $display("[TB] FAIL nonres_y: got %h expected %h", out_y, ey); end
        releaseResult();
    endtask

    task automatic test_random();
        logic [255:0] x, ey;
        logic [7:0]   pre;
        logic         ee;
        int           el, wc, lat;
        for (int i = 0; i < 5; i++) begin
            x   = rand256();
            pre = 8'h02 + 8'($urandom_range(0, 1));
            refModel(pre, x, ey, ee, el);
            applyStimulus(pre, x, wc);
            awaitOutput(lat);
            checks++; if (lat != el) begin errors++; $display("[TB] FAIL rand_latency #%0d: got %0d expected %0d", i, lat, el); end
            checks++; if (out_err !== ee) begin errors++; $display("[TB] FAIL rand_err #%0d: got %b expected %b", i, out_err, ee); end
            checks++; if (out_y !== ey) begin errors++; $display("[TB] FAIL rand_y #%0d: got %h expected %h", i, out_y, ey); end
            checks++; if (out_x !== x) begin errors++; $display("[TB] FAIL rand_x #%0d: got %h expected %h", i, out_x, x); end
            releaseResult();
        end
    endtask

    task automatic test_backpressure();
        int wc, lat;
        applyStimulus(8'h02, GX, wc);
        awaitOutput(lat);
        for (int i = 0; i < 20; i++) begin
            in_valid  = (i % 2 == 0);
            in_prefix = 8'h03;
            in_x      = rand256() >> 1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_y !== GY || out_x !== GX || out_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_cycle_%0d: got v=%b rdy=%b err=%b y=%h expected v=1 rdy=0 err=0 y=%h", i, out_valid, in_ready, out_err, out_y, GY);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_same_cycle_ready: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_valid_drop: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready_rise: got %b expected 1", in_ready); end
    endtask

    task automatic test_reset_mid_exp();
        int wc;
        applyStimulus(8'h02, GX, wc);
        repeat (101) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL busy_before_reset: got rdy=%b v=%b expected 0 0", in_ready, out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_err !== 1'b0 || out_x !== '0 || out_y !== '0) begin
            errors++;
            $display("[TB] FAIL midexp_reset_state: got rdy=%b v=%b err=%b x=%h y=%h expected 1 0 0 0 0", in_ready, out_valid, out_err, out_x, out_y);
        end
        test_generator(8'h02, GY, 1'b1);
    endtask

    initial begin
        test_reset();
        test_generator(8'h02, GY, 1'b1);
        test_generator(8'h03, GYN, 1'b0);
        test_reject();
        test_non_residue();
        test_random();
        test_backpressure();
        test_reset_mid_exp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
